// File: rtl/bfm_ahbl_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : bfm_ahbl_slave_mem
// Purpose  : AHB-Lite responder memory model for the BFM environment. It
//            accepts address phases, inserts a fixed number of wait states
//            and performs byte, halfword and word reads and writes into an
//            internal 32-bit word array. It also counts transfers that
//            complete with an OKAY response.
// Option   : `define BFM_AHBSLV_ERRRESP_EN enables a two-cycle ERROR
//            response for accesses outside the BASE window or with HSIZE>2.
//            When it is undefined, upper address bits alias into the array
//            and HRESP is tied low.
// Ports    : HCLK, HRESET (async, active-high)
//            HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0],
//            HBURST[2:0], HPROT[3:0], HMASTLOCK (the last three are ignored),
//            HWDATA[31:0], HREADYIN
//            HRDATA[31:0], HREADYOUT, HRESP, ACCESS_COUNT[15:0]
// Revision : 1.0 - initial release
// ============================================================================
module bfm_ahbl_slave_mem #(
  parameter int unsigned AWIDTH     = 10,
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int unsigned WAITSTATES = 0,
  parameter int unsigned TPD        = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [15:0] ACCESS_COUNT
);

  // The synthesizable model has no output delay; TPD is kept for the
  // parameter interface of the BFM environment only.
  localparam int unsigned unused_tpd = TPD;

  localparam logic [3:0]  c_ws    = 4'(WAITSTATES);
  localparam int unsigned c_depth = 2 ** AWIDTH;

  if ((BASE & ((32'h1 << (AWIDTH + 2)) - 32'h1)) != 32'h0) begin : g_base_align_check
    $error("BASE must be aligned to the size of the memory window");
  end
  if (WAITSTATES > 15) begin : g_waitstates_check
    $error("WAITSTATES must be in the range 0..15");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_wcnt;
  logic [3:0]          w_wcnt_nxt;
  logic [AWIDTH-1:0]   r_addr;
  logic [1:0]          r_lane;
  logic                r_write;
  logic [2:0]          r_size;
  logic [15:0]         r_count;
  logic [31:0]         r_mem [c_depth];
  logic                w_ready;
  logic                w_accept;
  logic                w_err;
  logic [3:0]          w_be;

  // Only states that present HREADYOUT=1 can close a data phase, so only
  // they may take a new address phase (pipelined, no bubble).
  assign w_ready  = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign w_accept = HSEL && HREADYIN && HTRANS[1] && w_ready;

`ifdef BFM_AHBSLV_ERRRESP_EN
  assign w_err = (HADDR[31:AWIDTH+2] != BASE[31:AWIDTH+2]) || (HSIZE > 3'd2);
  logic unused_sigs;
  assign unused_sigs = ^{HBURST, HPROT, HMASTLOCK};
`else
  assign w_err = 1'b0;
  // Upper address bits are deliberately ignored: the array aliases.
  logic unused_sigs;
  assign unused_sigs = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:AWIDTH+2]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_WAIT: begin
        // Counter is loaded with WAITSTATES, so WAIT lasts exactly that
        // many cycles before the single ready-high DATA cycle.
        w_wcnt_nxt = r_wcnt - 4'd1;
        if (r_wcnt <= 4'd1) begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef BFM_AHBSLV_ERRRESP_EN
      S_ERR1: w_state_nxt = S_ERR2;
`endif
      default: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = S_ERR1;
          end else if (c_ws == 4'd0) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_WAIT;
            w_wcnt_nxt  = c_ws;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
      r_addr  <= '0;
      r_lane  <= 2'd0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_accept) begin
        r_addr  <= HADDR[AWIDTH+1:2];
        r_lane  <= HADDR[1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
      end
      if (r_state == S_DATA) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  // Lane enables; low address bits beyond the transfer size are ignored,
  // and any size above word behaves as a word.
  always_comb begin
    case (r_size)
      3'd0:    w_be = 4'b0001 << r_lane;
      3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Memory is intentionally not reset. A reset forces the FSM out of DATA,
  // which discards any in-flight write.
  always_ff @(posedge HCLK) begin
    if ((r_state == S_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[r_addr][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HRDATA       = ((r_state == S_DATA) && !r_write) ? r_mem[r_addr] : 32'h0;
  assign HREADYOUT    = w_ready;
  assign ACCESS_COUNT = r_count;
`ifdef BFM_AHBSLV_ERRRESP_EN
  assign HRESP = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
  assign HRESP = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/bfm_ahbl_slave_mem.md
Name: bfm_ahbl_slave_mem

Overview:
- AHB-Lite slave/responder memory model for the BFM testbench environment. It is the responder end of the BFM AHB-Lite master bus.
- Decodes address/data phases, applies a fixed number of wait states, and performs byte/halfword/word reads and writes into an internal word array.
- Optionally returns a two-cycle ERROR response for out-of-window accesses.
- Exposes a completed-transfer counter so benches can check traffic.

Parameters:
- AWIDTH, 10, word-address bits; array depth 2^AWIDTH 32-bit words (4 KB at default).
- BASE, 32'h0000_0000, window base; must be aligned to 2^(AWIDTH+2).
- WAITSTATES, 0, wait cycles inserted in every OKAY data phase; legal range 0..15.
- TPD, 1, output delay in ns; simulation only.

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HBURST  in  3  ignored.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  32  write data, little-endian lanes.
- HREADYIN  in  1  bus-wide ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- ACCESS_COUNT  out  16  count of OKAY-completed NONSEQ/SEQ transfers.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, ACCESS_COUNT=0, FSM=IDLE. Memory contents are not cleared and are retained across reset.
- Address phase accepted when HSEL & HREADYIN & HTRANS[1] are all high. On acceptance, latch HADDR, HWRITE and HSIZE.
- IDLE/BUSY with HSEL=1, or HSEL=0: no transfer. Next cycle HREADYOUT=1, HRESP=0.
- FSM states are IDLE, WAIT, DATA, ERR1, ERR2.
- Accept, in range, WAITSTATES=0: go to DATA.
- Accept, in range, WAITSTATES>0: go to WAIT and load wait counter=WAITSTATES.
- WAIT: HREADYOUT=0. Decrement the counter each cycle; go to DATA when it reaches 0. The data phase therefore has exactly WAITSTATES low cycles, then one high cycle.
- DATA: HREADYOUT=1, HRESP=0.
  - Read: HRDATA = mem[latched word addr].
  - Write: HWDATA lanes are written at the closing edge.
  - ACCESS_COUNT increments at the closing edge and wraps 0xFFFF→0x0000.
- Pipelining: a new address phase may be accepted in DATA or ERR2 (HREADYIN=1), giving back-to-back transfers with no bubble.
- Write lane enables:
  - HSIZE=0: byte lane HADDR[1:0].
  - HSIZE=1: lanes {HADDR[1],0} and {HADDR[1],1}.
  - HSIZE=2: all four lanes.
- HRDATA outside a read DATA cycle is 0.
- Read-after-write to the same address, back-to-back: the read returns the newly written data.
- Word index = latched HADDR[AWIDTH+1:2].
- HSIZE>2 without the macro: treated as a word access.
- Misaligned addresses: the low bits are ignored for lane selection beyond HSIZE.
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. An errored transfer causes no memory write and no count.
- HRESET asserted mid-transfer: outputs go to reset values immediately, asynchronously. Any in-flight write is discarded.

Optional Feature:
- Macro: BFM_AHBSLV_ERRRESP_EN.
- Defined:
  - Accepted address with HADDR[31:AWIDTH+2] != BASE[31:AWIDTH+2], or HSIZE>2, goes to ERR1 → ERR2 → normal.
  - WAITSTATES is not applied to error responses.
- Undefined:
  - Upper address bits are ignored; out-of-window addresses alias into the array.
  - HSIZE>2 is treated as word.
  - The ERR states are not built; HRESP is tied to 0.

Test Plan:
- WAITSTATES=0: write 0x12345678 @0x10, then read @0x10 → HREADYOUT never low; read data phase HRDATA=0x12345678; ACCESS_COUNT=2.
- After the above, byte write HSIZE=0 @0x13 with HWDATA=0xAB000000, then read @0x10 → HRDATA=0xAB345678. Halfword write 0xCDEF @0x10 (HWDATA=0x0000CDEF), then read → 0xAB34CDEF.
- WAITSTATES=3: single read → HREADYOUT low exactly 3 cycles then high 1 cycle. Two pipelined NONSEQ writes → 4+4 data cycles, ACCESS_COUNT +2.
- Macro defined, AWIDTH=10: read @0x1000 → ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1), count unchanged. Macro undefined: the same read returns the contents of word 0.
- HSEL=1 with HTRANS=IDLE, then BUSY → HREADYOUT=1, HRESP=0, count unchanged.
- WAITSTATES=3: assert HRESET during the 2nd wait cycle of a write → HREADYOUT=1 and ACCESS_COUNT=0 immediately. A subsequent read of that address returns its pre-write value.
